// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Shares the common data bus between the RS-embedded ALU and the
//             load/store buffer. Each producer owns a 2-entry holding FIFO;
//             a round-robin arbiter pops one entry per cycle onto a registered
//             CDB broadcast port.
//  Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter #(
  parameter int RoB_WIDTH  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_signal,
  input  logic                 alu_valid,
  input  logic [RoB_WIDTH-1:0] alu_index,
  input  logic [31:0]          alu_data,
  output logic                 alu_ready,
  input  logic                 lsb_valid,
  input  logic [RoB_WIDTH-1:0] lsb_index,
  input  logic [31:0]          lsb_data,
  output logic                 lsb_ready,
  output logic                 CDB_update_en,
  output logic [RoB_WIDTH-1:0] CDB_update_index,
  output logic [31:0]          CDB_update_data,
  output logic                 grant_src,
  output logic                 idle
);

  // Count value at which a source FIFO is full.
  localparam logic [1:0] C_FULL  = 2'(FIFO_DEPTH);
  // Source encodings, also used as indices into the per-source vectors.
  localparam logic       SRC_ALU = 1'b0;
  localparam logic       SRC_LSB = 1'b1;

  // Per-source views of the producer ports (bit 0 = ALU, bit 1 = LSB).
  logic [1:0]                src_valid;
  logic [1:0][RoB_WIDTH-1:0] src_index;
  logic [1:0][31:0]          src_data;
  logic [1:0]                src_ready;
  logic [1:0]                src_push;
  logic [1:0]                src_pop;
  logic [1:0]                src_nonempty;
  logic [1:0][RoB_WIDTH-1:0] head_index;
  logic [1:0][31:0]          head_data;

  // Arbitration state and decisions.
  logic last_grant;
  logic grant_any;
  logic grant_sel;
  logic pop_en;

  assign src_valid = {lsb_valid, alu_valid};
  assign src_index = {lsb_index, alu_index};
  assign src_data  = {lsb_data, alu_data};

  assign alu_ready = src_ready[SRC_ALU];
  assign lsb_ready = src_ready[SRC_LSB];

  assign idle = !src_nonempty[SRC_ALU] && !src_nonempty[SRC_LSB];

  // A pop only happens on an enabled, non-flushing cycle with something to send.
  assign pop_en = rdy_in && !flush_signal && grant_any;

  // Round-robin choice made on the FIFO state before this edge's pushes, so a
  // freshly pushed entry can never be broadcast in the same cycle.
  always_comb begin
    grant_any = src_nonempty[SRC_ALU] || src_nonempty[SRC_LSB];
    grant_sel = SRC_ALU;
    if (src_nonempty[SRC_ALU] && src_nonempty[SRC_LSB]) begin
      grant_sel = ~last_grant;
    end else if (src_nonempty[SRC_LSB]) begin
      grant_sel = SRC_LSB;
    end
  end

  // One holding FIFO per producer.
  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [1:0]           count;
    logic                 head;
    logic                 tail;
    logic [RoB_WIDTH-1:0] mem_index [FIFO_DEPTH];
    logic [31:0]          mem_data  [FIFO_DEPTH];

    // Ready depends on the count before this edge; a same-cycle pop does not
    // open a slot in a full FIFO.
    assign src_ready[s]    = rst_in && rdy_in && (count != C_FULL);
    assign src_push[s]     = src_valid[s] && src_ready[s] && !flush_signal;
    assign src_pop[s]      = pop_en && (grant_sel == 1'(s));
    assign src_nonempty[s] = (count != 2'd0);
    assign head_index[s]   = mem_index[head];
    assign head_data[s]    = mem_data[head];

    // Pointer and occupancy bookkeeping; a flush empties the FIFO outright.
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        count <= 2'd0;
        head  <= 1'b0;
        tail  <= 1'b0;
      end else if (rdy_in) begin
        if (flush_signal) begin
          count <= 2'd0;
          head  <= 1'b0;
          tail  <= 1'b0;
        end else begin
          if (src_push[s]) begin
            tail <= ~tail;
          end
          if (src_pop[s]) begin
            head <= ~head;
          end
          case ({src_push[s], src_pop[s]})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
          endcase
        end
      end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk_in) begin
      if (src_push[s]) begin
        mem_index[tail] <= src_index[s];
        mem_data[tail]  <= src_data[s];
      end
    end
  end

  // Registered CDB broadcast and round-robin history.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      CDB_update_en    <= 1'b0;
      CDB_update_index <= '0;
      CDB_update_data  <= 32'd0;
      grant_src        <= SRC_ALU;
      last_grant       <= SRC_LSB;
    end else if (rdy_in) begin
      if (flush_signal) begin
        // Pretend the LSB went last so the ALU wins the first tie after flush.
        CDB_update_en <= 1'b0;
        last_grant    <= SRC_LSB;
      end else if (grant_any) begin
        CDB_update_en    <= 1'b1;
        CDB_update_index <= head_index[grant_sel];
        CDB_update_data  <= head_data[grant_sel];
        grant_src        <= grant_sel;
        last_grant       <= grant_sel;
      end else begin
        CDB_update_en <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter. Expected broadcasts are
//             queued as stimulus is driven and popped as the CDB fires.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int RW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          flush_signal;
  logic          alu_valid;
  logic [RW-1:0] alu_index;
  logic [31:0]   alu_data;
  logic          alu_ready;
  logic          lsb_valid;
  logic [RW-1:0] lsb_index;
  logic [31:0]   lsb_data;
  logic          lsb_ready;
  logic          CDB_update_en;
  logic [RW-1:0] CDB_update_index;
  logic [31:0]   CDB_update_data;
  logic          grant_src;
  logic          idle;

  typedef struct packed {
    logic          src;
    logic [RW-1:0] index;
    logic [31:0]   data;
  } bcast_t;

  bcast_t exp_q[$];
  int     n_pass  = 0;
  int     n_total = 0;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(.RoB_WIDTH(RW), .FIFO_DEPTH(2)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .flush_signal     (flush_signal),
    .alu_valid        (alu_valid),
    .alu_index        (alu_index),
    .alu_data         (alu_data),
    .alu_ready        (alu_ready),
    .lsb_valid        (lsb_valid),
    .lsb_index        (lsb_index),
    .lsb_data         (lsb_data),
    .lsb_ready        (lsb_ready),
    .CDB_update_en    (CDB_update_en),
    .CDB_update_index (CDB_update_index),
    .CDB_update_data  (CDB_update_data),
    .grant_src        (grant_src),
    .idle             (idle)
  );

  // Advance one clock; if the edge was enabled and the CDB fired, the
  // broadcast must match the head of the scoreboard.
  task automatic cycle();
    logic   live;
    bcast_t got;
    bcast_t want;
    live = rst_in && rdy_in;
    @(posedge clk_in);
    #1;
    if (live && CDB_update_en) begin
      got = {grant_src, CDB_update_index, CDB_update_data};
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL bcast_unexpected: got src=%0d idx=%0d data=%h, required no broadcast",
                 got.src, got.index, got.data);
      end else begin
        want = exp_q.pop_front();
        if (got !== want)
          $display("FAIL bcast_order: got src=%0d idx=%0d data=%h, required src=%0d idx=%0d data=%h",
                   got.src, got.index, got.data, want.src, want.index, want.data);
        else n_pass++;
      end
    end
  endtask

  task automatic idle_inputs();
    flush_signal = 1'b0;
    alu_valid    = 1'b0;
    lsb_valid    = 1'b0;
    alu_index    = '0;
    lsb_index    = '0;
    alu_data     = 32'd0;
    lsb_data     = 32'd0;
  endtask

  // Pulse reset between clock edges (caller sits just after a rising edge).
  task automatic do_reset();
    idle_inputs();
    rdy_in = 1'b1;
    rst_in = 1'b0;
    #2;
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
    #1;
    n_total++; if (CDB_update_en !== 1'b0) $display("FAIL rst_en: got %0d, required 0", CDB_update_en); else n_pass++;
    n_total++; if (CDB_update_index !== 4'd0) $display("FAIL rst_index: got %0d, required 0", CDB_update_index); else n_pass++;
    n_total++; if (CDB_update_data !== 32'd0) $display("FAIL rst_data: got %h, required 0", CDB_update_data); else n_pass++;
    n_total++; if (grant_src !== 1'b0) $display("FAIL rst_grant: got %0d, required 0", grant_src); else n_pass++;
    n_total++; if (alu_ready !== 1'b0) $display("FAIL rst_alu_ready: got %0d, required 0", alu_ready); else n_pass++;
    n_total++; if (lsb_ready !== 1'b0) $display("FAIL rst_lsb_ready: got %0d, required 0", lsb_ready); else n_pass++;
    n_total++; if (idle !== 1'b1) $display("FAIL rst_idle: got %0d, required 1", idle); else n_pass++;
    rst_in = 1'b1;
    #1;
    n_total++; if (alu_ready !== 1'b1) $display("FAIL post_rst_ready: got %0d, required 1", alu_ready); else n_pass++;
    cycle();
  endtask

  task automatic test_single();
    alu_valid = 1'b1; alu_index = 4'd3; alu_data = 32'h12;
    exp_q.push_back({1'b0, 4'd3, 32'h12});
    cycle();
    alu_valid = 1'b0;
    n_total++; if (idle !== 1'b0) $display("FAIL single_idle_busy: got %0d, required 0", idle); else n_pass++;
    n_total++; if (CDB_update_en !== 1'b0) $display("FAIL single_no_bypass: got %0d, required 0", CDB_update_en); else n_pass++;
    cycle();
    n_total++; if (CDB_update_en !== 1'b1) $display("FAIL single_en: got %0d, required 1", CDB_update_en); else n_pass++;
    cycle();
    n_total++; if (CDB_update_en !== 1'b0) $display("FAIL single_en_drop: got %0d, required 0", CDB_update_en); else n_pass++;
    n_total++; if (idle !== 1'b1) $display("FAIL single_idle: got %0d, required 1", idle); else n_pass++;
  endtask

  task automatic test_contention();
    do_reset();
    exp_q.push_back({1'b0, 4'd1, 32'hA});
    exp_q.push_back({1'b1, 4'd5, 32'hC});
    exp_q.push_back({1'b0, 4'd2, 32'hB});
    exp_q.push_back({1'b1, 4'd6, 32'hD});
    alu_valid = 1'b1; alu_index = 4'd1; alu_data = 32'hA;
    lsb_valid = 1'b1; lsb_index = 4'd5; lsb_data = 32'hC;
    cycle();
    alu_index = 4'd2; alu_data = 32'hB;
    lsb_index = 4'd6; lsb_data = 32'hD;
    cycle();
    alu_valid = 1'b0; lsb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (CDB_update_en !== 1'b1) $display("FAIL contention_back_to_back: got %0d, required 1", CDB_update_en); else n_pass++;
      cycle();
    end
    n_total++; if (exp_q.size() !== 0) $display("FAIL contention_drain: got %0d left, required 0", exp_q.size()); else n_pass++;
    n_total++; if (idle !== 1'b1) $display("FAIL contention_idle: got %0d, required 1", idle); else n_pass++;
    cycle();
    n_total++; if (CDB_update_en !== 1'b0) $display("FAIL contention_en_drop: got %0d, required 0", CDB_update_en); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    exp_q.push_back({1'b0, 4'd8,  32'h100});
    exp_q.push_back({1'b1, 4'd9,  32'h200});
    exp_q.push_back({1'b0, 4'd10, 32'h101});
    exp_q.push_back({1'b1, 4'd11, 32'h201});
    exp_q.push_back({1'b0, 4'd12, 32'h102});
    alu_valid = 1'b1; alu_index = 4'd8;  alu_data = 32'h100;
    lsb_valid = 1'b1; lsb_index = 4'd9;  lsb_data = 32'h200;
    cycle();
    alu_index = 4'd10; alu_data = 32'h101;
    lsb_index = 4'd11; lsb_data = 32'h201;
    cycle();
    alu_index = 4'd12; alu_data = 32'h102;
    lsb_valid = 1'b0;
    n_total++; if (alu_ready !== 1'b1) $display("FAIL bp_ready_one: got %0d, required 1", alu_ready); else n_pass++;
    cycle();
    alu_index = 4'd14; alu_data = 32'h103;
    n_total++; if (alu_ready !== 1'b0) $display("FAIL bp_ready_full: got %0d, required 0", alu_ready); else n_pass++;
    cycle();
    n_total++; if (alu_ready !== 1'b1) $display("FAIL bp_ready_reassert: got %0d, required 1", alu_ready); else n_pass++;
    alu_valid = 1'b0;
    cycle();
    cycle();
    cycle();
    n_total++; if (exp_q.size() !== 0) $display("FAIL bp_drain: got %0d left, required 0", exp_q.size()); else n_pass++;
    n_total++; if (CDB_update_en !== 1'b0) $display("FAIL bp_en_drop: got %0d, required 0", CDB_update_en); else n_pass++;
    n_total++; if (idle !== 1'b1) $display("FAIL bp_idle: got %0d, required 1", idle); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    exp_q.push_back({1'b0, 4'd1, 32'hF0});
    alu_valid = 1'b1; alu_index = 4'd1; alu_data = 32'hF0;
    lsb_valid = 1'b1; lsb_index = 4'd2; lsb_data = 32'hE0;
    cycle();
    alu_index = 4'd3; alu_data = 32'hF1;
    lsb_index = 4'd4; lsb_data = 32'hE1;
    cycle();
    flush_signal = 1'b1;
    alu_index = 4'd7; alu_data = 32'hF2;
    lsb_index = 4'd6; lsb_data = 32'hE2;
    cycle();
    flush_signal = 1'b0;
    n_total++; if (CDB_update_en !== 1'b0) $display("FAIL flush_en: got %0d, required 0", CDB_update_en); else n_pass++;
    n_total++; if (idle !== 1'b1) $display("FAIL flush_idle: got %0d, required 1", idle); else n_pass++;
    n_total++; if (lsb_ready !== 1'b1) $display("FAIL flush_lsb_ready: got %0d, required 1", lsb_ready); else n_pass++;
    exp_q.push_back({1'b0, 4'd8, 32'h80});
    exp_q.push_back({1'b1, 4'd9, 32'h90});
    alu_index = 4'd8; alu_data = 32'h80;
    lsb_index = 4'd9; lsb_data = 32'h90;
    cycle();
    alu_valid = 1'b0; lsb_valid = 1'b0;
    cycle();
    cycle();
    cycle();
    n_total++; if (exp_q.size() !== 0) $display("FAIL flush_drain: got %0d left, required 0", exp_q.size()); else n_pass++;
    n_total++; if (idle !== 1'b1) $display("FAIL flush_final_idle: got %0d, required 1", idle); else n_pass++;
  endtask

  task automatic test_pause();
    do_reset();
    exp_q.push_back({1'b0, 4'd7, 32'h77});
    exp_q.push_back({1'b1, 4'd6, 32'h66});
    alu_valid = 1'b1; alu_index = 4'd7; alu_data = 32'h77;
    lsb_valid = 1'b1; lsb_index = 4'd6; lsb_data = 32'h66;
    cycle();
    alu_valid = 1'b0; lsb_valid = 1'b0;
    cycle();
    rdy_in = 1'b0;
    alu_valid = 1'b1; alu_index = 4'd13; alu_data = 32'h13;
    lsb_valid = 1'b1; lsb_index = 4'd5;  lsb_data = 32'h55;
    #1;
    n_total++; if (alu_ready !== 1'b0) $display("FAIL pause_alu_ready: got %0d, required 0", alu_ready); else n_pass++;
    n_total++; if (lsb_ready !== 1'b0) $display("FAIL pause_lsb_ready: got %0d, required 0", lsb_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_total++; if (CDB_update_en !== 1'b1) $display("FAIL pause_hold_en: got %0d, required 1", CDB_update_en); else n_pass++;
      n_total++; if (CDB_update_index !== 4'd7) $display("FAIL pause_hold_index: got %0d, required 7", CDB_update_index); else n_pass++;
      n_total++; if (CDB_update_data !== 32'h77) $display("FAIL pause_hold_data: got %h, required 77", CDB_update_data); else n_pass++;
      n_total++; if (idle !== 1'b0) $display("FAIL pause_hold_queue: got %0d, required 0", idle); else n_pass++;
    end
    rdy_in = 1'b1;
    alu_valid = 1'b0; lsb_valid = 1'b0;
    cycle();
    n_total++; if (grant_src !== 1'b1) $display("FAIL pause_resume_src: got %0d, required 1", grant_src); else n_pass++;
    cycle();
    n_total++; if (CDB_update_en !== 1'b0) $display("FAIL pause_en_drop: got %0d, required 0", CDB_update_en); else n_pass++;
    n_total++; if (idle !== 1'b1) $display("FAIL pause_idle: got %0d, required 1", idle); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL pause_drain: got %0d left, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    exp_q.push_back({1'b0, 4'd9, 32'h99});
    alu_valid = 1'b1; alu_index = 4'd9;  alu_data = 32'h99;
    lsb_valid = 1'b1; lsb_index = 4'd10; lsb_data = 32'hAA;
    cycle();
    alu_valid = 1'b0; lsb_valid = 1'b0;
    cycle();
    #1;
    rst_in = 1'b0;
    #1;
    n_total++; if (CDB_update_en !== 1'b0) $display("FAIL arst_en: got %0d, required 0", CDB_update_en); else n_pass++;
    n_total++; if (CDB_update_index !== 4'd0) $display("FAIL arst_index: got %0d, required 0", CDB_update_index); else n_pass++;
    n_total++; if (CDB_update_data !== 32'd0) $display("FAIL arst_data: got %h, required 0", CDB_update_data); else n_pass++;
    n_total++; if (grant_src !== 1'b0) $display("FAIL arst_grant: got %0d, required 0", grant_src); else n_pass++;
    n_total++; if (idle !== 1'b1) $display("FAIL arst_idle: got %0d, required 1", idle); else n_pass++;
    n_total++; if (lsb_ready !== 1'b0) $display("FAIL arst_lsb_ready: got %0d, required 0", lsb_ready); else n_pass++;
    #1;
    rst_in = 1'b1;
    cycle();
    n_total++; if (CDB_update_en !== 1'b0) $display("FAIL arst_no_bcast: got %0d, required 0", CDB_update_en); else n_pass++;
    n_total++; if (idle !== 1'b1) $display("FAIL arst_empty: got %0d, required 1", idle); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL arst_drain: got %0d left, required 0", exp_q.size()); else n_pass++;
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush();
    test_pause();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Guard against a run that never reaches its summary.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
